// File: rtl/downlink_transmitter_if.sv
// Frame handoff from the DL FEC engine/FIFO into the downlink serializer.
interface downlink_transmitter_if #(parameter int LONG_BITS = 80);
  logic                 frame_valid;
  logic                 frame_ready;
  logic                 frame_enc_used;
  logic [LONG_BITS-1:0] frame_data;

  modport master (output frame_valid, frame_enc_used, frame_data, input frame_ready);
  modport slave  (input frame_valid, frame_enc_used, frame_data, output frame_ready);
endinterface

// File: rtl/downlink_transmitter.sv
// Downlink serializer: preamble + FEC frame bits, LSB first, at a programmable bit period.
// Optional DL_TX_PARITY_EN appends one even-parity bit after the last frame bit.
module downlink_transmitter #(
  parameter int SERIAL_DIV_WIDTH = 8,
  parameter int PREAMBLE_COUNT   = 8,
  parameter int SHORT_BITS       = 24,
  parameter int LONG_BITS        = 80,
  parameter int GAP_BITS         = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SERIAL_DIV_WIDTH-1:0] clk_div,
  input  logic                        tx_enable,
  downlink_transmitter_if.slave       frm,
  output logic                        dl_out,
  output logic                        dl_en,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_aborted,
  output logic [7:0]                  frame_cnt
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_GAP      = 2'd3;
`ifdef DL_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int CW = $clog2(LONG_BITS + PREAMBLE_COUNT + GAP_BITS + 2);
  typedef logic [CW-1:0] cnt_t;

  logic [1:0]                  state_q, state_d;
  logic                        lead_q, lead_d;
  logic                        short_q, short_d;
  logic [SERIAL_DIV_WIDTH-1:0] div_q, div_d, tick_q, tick_d;
  cnt_t                        bit_q, bit_d;
  logic [LONG_BITS-1:0]        sreg_q, sreg_d;
  logic                        done_q, done_d, abort_q, abort_d;
  logic [7:0]                  fcnt_q, fcnt_d;
  logic                        accept, last_tick, last_data, data_bit;

  assign frm.frame_ready = (state_q == S_IDLE) && tx_enable;
  assign accept          = frm.frame_valid && frm.frame_ready;
  assign last_tick       = (tick_q == div_q);
  assign last_data       = (bit_q == (short_q ? cnt_t'(SHORT_BITS + PAR_BITS - 1)
                                              : cnt_t'(LONG_BITS + PAR_BITS - 1)));

`ifdef DL_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      par_q <= 1'b0;
    else if (accept) par_q <= frm.frame_enc_used ? ^frm.frame_data[SHORT_BITS-1:0]
                                                 : ^frm.frame_data;
  assign data_bit = last_data ? par_q : sreg_q[0];
`else
  assign data_bit = sreg_q[0];
`endif

  // The cycle after accept is a lead cycle (line still idle) so the first
  // preamble bit appears one cycle after the accept edge and the FSM leaves
  // S_DATA on the same edge frame_done rises.
  always_comb begin
    state_d = state_q;
    lead_d  = lead_q;
    short_d = short_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_PREAMBLE;
        lead_d  = 1'b1;
        short_d = frm.frame_enc_used;
        div_d   = clk_div;
        sreg_d  = frm.frame_data;
        tick_d  = '0;
        bit_d   = '0;
      end
      S_PREAMBLE: begin
        if (lead_q) lead_d = 1'b0;
        else if (!last_tick) tick_d = tick_q + 1'b1;
        else begin
          tick_d = '0;
          if (bit_q == cnt_t'(PREAMBLE_COUNT - 1)) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else bit_d = bit_q + 1'b1;
        end
      end
      S_DATA: begin
        if (!last_tick) tick_d = tick_q + 1'b1;
        else begin
          tick_d = '0;
          sreg_d = sreg_q >> 1;
          if (last_data) begin
            state_d = (GAP_BITS > 0) ? S_GAP : S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 8'd1;
          end else bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        if (!last_tick) tick_d = tick_q + 1'b1;
        else begin
          tick_d = '0;
          if (bit_q == cnt_t'(GAP_BITS - 1)) state_d = S_IDLE;
          else bit_d = bit_q + 1'b1;
        end
      end
    endcase
    // Disable drops the frame outright; it is never retried.
    if (state_q != S_IDLE && !tx_enable) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      abort_d = 1'b1;
      fcnt_d  = fcnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lead_q  <= 1'b0;
      short_q <= 1'b0;
      div_q   <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lead_q  <= lead_d;
      short_q <= short_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign dl_en         = ((state_q == S_PREAMBLE) && !lead_q) || (state_q == S_DATA);
  assign dl_out        = ((state_q == S_PREAMBLE) && !lead_q) ? ~bit_q[0] :
                         (state_q == S_DATA) ? data_bit : 1'b0;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = done_q;
  assign frame_aborted = abort_q;
  assign frame_cnt     = fcnt_q;
endmodule

// File: tb/tb_downlink_transmitter.sv
// Scoreboard bench: driver pushes the expected line bitstream per accepted frame,
// a forked monitor pops and compares on every driven bit, frame_done and frame_aborted.
module tb_downlink_transmitter;
  localparam int DIVW  = 8;
  localparam int PRE   = 8;
  localparam int SB    = 24;
  localparam int LB    = 80;
  localparam int GAP   = 2;
  localparam int LIMIT = 2000;
`ifdef DL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DIVW-1:0] clk_div = '0;
  logic            tx_enable = 1'b1;
  logic            dl_out, dl_en, busy, frame_done, frame_aborted;
  logic [7:0]      frame_cnt;

  downlink_transmitter_if #(.LONG_BITS(LB)) frm();

  downlink_transmitter #(
    .SERIAL_DIV_WIDTH(DIVW), .PREAMBLE_COUNT(PRE), .SHORT_BITS(SB),
    .LONG_BITS(LB), .GAP_BITS(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .tx_enable(tx_enable), .frm(frm),
    .dl_out(dl_out), .dl_en(dl_en), .busy(busy), .frame_done(frame_done),
    .frame_aborted(frame_aborted), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int acc; int len; int div; logic [7:0] cnt; } frame_t;
  bit         bitq[$];
  frame_t     frameq[$];
  int         checks = 0, errors = 0;
  int         run_len = 0, last_done = 0, last_div = 0, abort_req = 0, abort_seen = 0;
  logic [7:0] exp_cnt = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: what the line must carry, one entry per clock while dl_en is high.
  task automatic model_push(input bit enc, input logic [LB-1:0] d, input int div, input int acc);
    int n;
    bit p;
    frame_t r;
    n = enc ? SB : LB;
    p = 1'b0;
    for (int i = 0; i < PRE; i++) repeat (div + 1) bitq.push_back(i % 2 == 0);
    for (int i = 0; i < n; i++) begin
      p ^= d[i];
      repeat (div + 1) bitq.push_back(d[i]);
    end
    if (PAR == 1) repeat (div + 1) bitq.push_back(p);
    r.acc = acc;
    r.len = (PRE + n + PAR) * (div + 1);
    r.div = div;
    r.cnt = exp_cnt + 8'd1;
    frameq.push_back(r);
  endtask

  task automatic monitor();
    frame_t rec;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dl_en) begin
          if (run_len == 0) begin
            if (frameq.size() == 0) check("frame_in_flight", frameq.size(), 1);
            else check("en_latency", cyc - frameq[0].acc, 1);
          end
          run_len++;
          if (bitq.size() == 0) check("bits_pending", bitq.size(), 1);
          else check("dl_out", dl_out, bitq.pop_front());
        end
        if (frame_done) begin
          if (frameq.size() == 0) check("done_frame_in_flight", frameq.size(), 1);
          else begin
            rec = frameq.pop_front();
            check("en_len", run_len, rec.len);
            check("frame_cnt", frame_cnt, rec.cnt);
            check("done_en_low", dl_en, 0);
            check("bits_consumed", bitq.size(), 0);
            exp_cnt   = rec.cnt;
            last_done = cyc;
            last_div  = rec.div;
          end
          run_len = 0;
        end
        if (frame_aborted) begin
          abort_seen++;
          check("abort_cnt_hold", frame_cnt, exp_cnt);
          check("abort_en_low", dl_en, 0);
          bitq.delete();
          if (frameq.size() > 0) frameq.delete(0);
          run_len = 0;
        end
      end
    end
  endtask

  task automatic rand80(output logic [LB-1:0] d);
    d[31:0]  = $urandom();
    d[63:32] = $urandom();
    d[79:64] = 16'($urandom());
  endtask

  // Called just after a posedge; leaves frame_valid high so a following
  // call keeps the handshake continuous.
  task automatic send(input bit enc, input logic [LB-1:0] d, input int div, input bit chk_gap);
    int t, acc;
    t = 0;
    frm.frame_enc_used = enc;
    frm.frame_data     = d;
    clk_div            = DIVW'(div);
    frm.frame_valid    = 1'b1;
    while (!frm.frame_ready && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait_bound", int'(t < LIMIT), 1);
    if (t >= LIMIT) begin
      frm.frame_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    model_push(enc, d, div, acc);
    if (chk_gap) check("b2b_gap", acc - last_done, GAP * (last_div + 1) + 1);
    clk_div = DIVW'($urandom_range(0, 255));  // mid-frame change must be ignored
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((frameq.size() != 0 || busy) && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_wait_bound", int'(t < LIMIT), 1);
  endtask

  initial begin
    logic [LB-1:0] d;
    bit b2b;
    frm.frame_valid    = 1'b0;
    frm.frame_enc_used = 1'b0;
    frm.frame_data     = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_dl_en", dl_en, 0);
    check("rst_dl_out", dl_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_aborted", frame_aborted, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_ready", frm.frame_ready, 1);

    // Short frame 24'hA5C30F, clk_div=0, junk in the unused upper bits.
    rand80(d);
    d[23:0] = 24'hA5C30F;
    send(1'b1, d, 0, 1'b0);
    frm.frame_valid = 1'b0;
    wait_idle();

    // Long all-ones at clk_div=3, then a queued short frame to measure the gap.
    send(1'b0, '1, 3, 1'b0);
    rand80(d);
    send(1'b1, d, 0, 1'b1);
    frm.frame_valid = 1'b0;
    wait_idle();

    // Three short frames with valid held high throughout.
    for (int k = 0; k < 3; k++) begin
      rand80(d);
      send(1'b1, d, 0, k > 0);
    end
    frm.frame_valid = 1'b0;
    wait_idle();

    // Abort: tx_enable low during cycle 20 of a long frame.
    rand80(d);
    send(1'b0, d, 0, 1'b0);
    frm.frame_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 tx_enable = 1'b0;
    abort_req++;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pulse", abort_seen, abort_req);
    check("abort_busy", busy, 0);
    frm.frame_valid = 1'b1;  // must not be accepted while disabled
    repeat (3) begin
      check("ready_disabled", frm.frame_ready, 0);
      @(posedge clk); #1;
    end
    check("disabled_no_accept", busy, 0);
    frm.frame_valid = 1'b0;
    tx_enable = 1'b1;
    #1 check("ready_reenabled", frm.frame_ready, 1);
    @(posedge clk); #1;

    // Async reset in the middle of the preamble.
    rand80(d);
    send(1'b0, d, 1, 1'b0);
    frm.frame_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_dl_out", dl_out, 0);
    check("arst_dl_en", dl_en, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", frame_cnt, 0);
    bitq.delete();
    frameq.delete();
    run_len = 0;
    exp_cnt = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rand80(d);
    send(1'b1, d, 2, 1'b0);
    frm.frame_valid = 1'b0;
    wait_idle();

    // Randomized traffic, mixing back-to-back and idle-separated frames.
    b2b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      rand80(d);
      send(1'($urandom_range(0, 1)), d, $urandom_range(0, 3), b2b);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) begin
        frm.frame_valid = 1'b0;
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
    end
    frm.frame_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("abort_balance", abort_seen, abort_req);
    check("final_cnt", frame_cnt, exp_cnt);
    check("final_bits_empty", bitq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
